serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder_pkg.sv | 13 +
 rtl/serial_adder_if.sv | 42 ++++
 rtl/full_adder.sv | 13 +
 rtl/serial_adder.sv | 111 +++++++++++
 tb/tb_serial_adder.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
// Optional signed-overflow output is enabled by SERIAL_ADDER_OVF_EN.
package serial_adder_pkg;

  localparam int SERIAL_ADDER_DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_adder_if.sv
// Start/operand/result bundle between requester and serial adder.
// ovf exists only when SERIAL_ADDER_OVF_EN is defined.
interface serial_adder_if
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = SERIAL_ADDER_DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout, ovf
  );
`else
  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );
`endif

endinterface

// File: rtl/full_adder.sv
// Single-bit full adder used once per bit-cycle by the serial adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: LSB-first, one full adder, WIDTH cycles per add.
// Define SERIAL_ADDER_OVF_EN to add the signed-overflow output.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = SERIAL_ADDER_DEFAULT_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  serial_adder_if.slave sa_if
);

  localparam int             CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_d;
  logic [WIDTH-1:0] sum_q;
  logic [CW-1:0]    cnt_q;
  logic             c_q;
  logic             cout_q;
  logic             busy_q;
  logic             done_q;
  logic             fa_s;
  logic             fa_c;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q;
`endif

  full_adder u_fa (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .cin  (c_q),
    .sum  (fa_s),
    .cout (fa_c)
  );

  // New sum bit enters at the MSB; after WIDTH shifts it is aligned.
  assign acc_d = (acc_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (sa_if.start) begin
            a_q     <= sa_if.a;
            b_q     <= sa_if.b;
            c_q     <= sa_if.cin;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          c_q   <= fa_c;
          acc_q <= acc_d;
          if (cnt_q == LAST) begin
            sum_q   <= acc_d;
            cout_q  <= fa_c;
`ifdef SERIAL_ADDER_OVF_EN
            // c_q here is the carry into the MSB
            ovf_q   <= c_q ^ fa_c;
`endif
            busy_q  <= 1'b0;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DONE: begin
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign sa_if.busy = busy_q;
  assign sa_if.done = done_q;
  assign sa_if.sum  = sum_q;
  assign sa_if.cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign sa_if.ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder at WIDTH 8, 1 and 16 with a timeline model.
// Covers SERIAL_ADDER_OVF_EN builds as well as the default build.
module tb_serial_adder;

  localparam int W8 = serial_adder_pkg::SERIAL_ADDER_DEFAULT_WIDTH;
  localparam int NW[3] = '{W8, 1, 16};
  localparam int FA_TT[8] = '{0, 1, 1, 2, 1, 2, 2, 3};

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(W8)) i8 ();
  serial_adder_if #(.WIDTH(1))  i1 ();
  serial_adder_if #(.WIDTH(16)) i16 ();

  serial_adder #(.WIDTH(W8)) u8 (.clk(clk), .rst(rst), .sa_if(i8));
  serial_adder #(.WIDTH(1))  u1 (.clk(clk), .rst(rst), .sa_if(i1));
  serial_adder #(.WIDTH(16)) u16 (.clk(clk), .rst(rst), .sa_if(i16));

  logic ov8, ov1, ov16;
`ifdef SERIAL_ADDER_OVF_EN
  assign ov8  = i8.ovf;
  assign ov1  = i1.ovf;
  assign ov16 = i16.ovf;
`else
  assign ov8  = 1'b0;
  assign ov1  = 1'b0;
  assign ov16 = 1'b0;
`endif

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Reference result from plain integer arithmetic.
  function automatic void ref_add(input int w, input logic [63:0] a,
                                  input logic [63:0] b, input logic c,
                                  output logic [63:0] s,
                                  output logic co, output logic ov);
    logic [64:0] full;
    logic [63:0] m;
    m    = (64'd1 << w) - 64'd1;
    full = {1'b0, a & m} + {1'b0, b & m} + {64'd0, c};
    s    = full[63:0] & m;
    co   = full[w];
    ov   = (a[w-1] == b[w-1]) && (s[w-1] != a[w-1]);
  endfunction

  // Timeline model: per DUT, the cycle an add was accepted.
  longint      cyc = 0;
  bit          armed = 0;
  longint      acc_at[3] = '{-1, -1, -1};
  longint      free_at[3] = '{0, 0, 0};
  logic [63:0] m_sum[3], p_sum[3];
  logic        m_cout[3], p_cout[3], m_ovf[3], p_ovf[3];
  logic        e_busy[3], e_done[3];
  logic        st[3], ic[3];
  logic [63:0] ia[3], ib[3];
  logic        r;
  logic [127:0] act[3], exp_v[3];

  always begin
    @(posedge clk);
    r = rst;
    st[0] = i8.start;  ia[0] = 64'(i8.a);  ib[0] = 64'(i8.b);  ic[0] = i8.cin;
    st[1] = i1.start;  ia[1] = 64'(i1.a);  ib[1] = 64'(i1.b);  ic[1] = i1.cin;
    st[2] = i16.start; ia[2] = 64'(i16.a); ib[2] = 64'(i16.b); ic[2] = i16.cin;
    cyc++;
    for (int k = 0; k < 3; k++) begin
      if (r) begin
        acc_at[k] = -1;
        free_at[k] = 0;
        m_sum[k] = '0;
        m_cout[k] = 1'b0;
        m_ovf[k] = 1'b0;
      end else begin
        if (acc_at[k] >= 0 && cyc == acc_at[k] + NW[k]) begin
          m_sum[k] = p_sum[k];
          m_cout[k] = p_cout[k];
          m_ovf[k] = p_ovf[k];
        end
        if (cyc >= free_at[k] && st[k]) begin
          acc_at[k] = cyc;
          free_at[k] = cyc + NW[k] + 2;
          ref_add(NW[k], ia[k], ib[k], ic[k], p_sum[k], p_cout[k], p_ovf[k]);
        end
      end
      e_busy[k] = !r && acc_at[k] >= 0 && cyc >= acc_at[k] &&
                  cyc < acc_at[k] + NW[k];
      e_done[k] = !r && acc_at[k] >= 0 && cyc == acc_at[k] + NW[k] + 1;
    end
    if (r) armed = 1;
    #1;
    if (armed) begin
      act[0] = {60'd0, i8.busy, i8.done, i8.cout, ov8, 64'(i8.sum)};
      act[1] = {60'd0, i1.busy, i1.done, i1.cout, ov1, 64'(i1.sum)};
      act[2] = {60'd0, i16.busy, i16.done, i16.cout, ov16, 64'(i16.sum)};
      for (int k = 0; k < 3; k++) begin
`ifdef SERIAL_ADDER_OVF_EN
        exp_v[k] = {60'd0, e_busy[k], e_done[k], m_cout[k], m_ovf[k], m_sum[k]};
`else
        exp_v[k] = {60'd0, e_busy[k], e_done[k], m_cout[k], 1'b0, m_sum[k]};
`endif
        chk($sformatf("cyc%0d_w%0d", cyc, NW[k]), act[k], exp_v[k]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One WIDTH-8 add; optional re-pulse of start or reset mid-run.
  task automatic op8(input logic [7:0] a, input logic [7:0] b,
                     input logic c, input int rep, input int rstat,
                     output int lat, output int nbusy, output int ndone);
    i8.a = a;
    i8.b = b;
    i8.cin = c;
    i8.start = 1'b1;
    tick();
    i8.start = 1'b0;
    lat = -1;
    ndone = 0;
    nbusy = i8.busy ? 1 : 0;
    for (int j = 1; j <= 14; j++) begin
      tick();
      if (j == rstat + 1)
        chk("rst_abort", {i8.busy, i8.done, i8.cout, ov8, i8.sum}, '0);
      if (i8.busy) nbusy++;
      if (i8.done) begin
        ndone++;
        if (lat < 0) lat = j;
      end
      i8.start = (j == rep);
      if (j == rep) begin
        i8.a = ~a;
        i8.b = ~b;
      end
      rst = (j == rstat);
    end
  endtask

  int lat, nb, nd, cnt;

  initial begin
    i8.start = 0;  i8.a = '0;  i8.b = '0;  i8.cin = 0;
    i1.start = 0;  i1.a = '0;  i1.b = '0;  i1.cin = 0;
    i16.start = 0; i16.a = '0; i16.b = '0; i16.cin = 0;
    rst = 1'b1;
    repeat (2) tick();
    chk("rst8", {i8.busy, i8.done, i8.cout, ov8, i8.sum}, '0);
    chk("rst1", {i1.busy, i1.done, i1.cout, ov1, i1.sum}, '0);
    chk("rst16", {i16.busy, i16.done, i16.cout, ov16, i16.sum}, '0);
    rst = 1'b0;
    tick();

    op8(8'hFF, 8'h01, 1'b0, 0, -5, lat, nb, nd);
    chk("ff01_lat", 128'(lat), 128'd9);
    chk("ff01_busy", 128'(nb), 128'd8);
    chk("ff01_ndone", 128'(nd), 128'd1);
    chk("ff01_res", {i8.cout, i8.sum}, 9'h100);

    op8(8'h7F, 8'h01, 1'b0, 0, -5, lat, nb, nd);
    chk("7f01_res", {i8.cout, i8.sum}, 9'h080);
`ifdef SERIAL_ADDER_OVF_EN
    chk("7f01_ovf", 128'(i8.ovf), 128'd1);
`endif
    op8(8'h80, 8'h80, 1'b0, 0, -5, lat, nb, nd);
    chk("8080_res", {i8.cout, i8.sum}, 9'h100);
`ifdef SERIAL_ADDER_OVF_EN
    chk("8080_ovf", 128'(i8.ovf), 128'd1);
`endif

    op8(8'h12, 8'h34, 1'b1, 2, -5, lat, nb, nd);
    chk("repulse_ndone", 128'(nd), 128'd1);
    chk("repulse_sum", {i8.cout, i8.sum}, 9'h047);

    op8(8'h0F, 8'h01, 1'b0, 0, 3, lat, nb, nd);
    chk("abort_ndone", 128'(nd), 128'd0);
    op8(8'h20, 8'h22, 1'b0, 0, -5, lat, nb, nd);
    chk("after_rst_lat", 128'(lat), 128'd9);
    chk("after_rst_sum", {i8.cout, i8.sum}, 9'h042);

    for (int v = 0; v < 8; v++) begin
      i1.a = v[2];
      i1.b = v[1];
      i1.cin = v[0];
      i1.start = 1'b1;
      tick();
      i1.start = 1'b0;
      lat = -1;
      for (int j = 1; j <= 4; j++) begin
        tick();
        if (i1.done && lat < 0) lat = j;
      end
      chk($sformatf("w1_lat_%0d", v), 128'(lat), 128'd2);
      chk($sformatf("w1_tt_%0d", v), {i1.cout, i1.sum}, 128'(FA_TT[v]));
    end

    cnt = 0;
    i16.a = 16'($urandom);
    i16.b = 16'($urandom);
    i16.cin = 1'($urandom);
    i16.start = 1'b1;
    for (int i = 0; i < 18000; i++) begin
      tick();
      if (i16.done) cnt++;
      i16.a = 16'($urandom);
      i16.b = 16'($urandom);
      i16.cin = 1'($urandom);
    end
    i16.start = 1'b0;
    repeat (20) tick();
    chk("w16_ndone", 128'(cnt), 128'd1000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
